// File: rtl/collision_life_ctrl.sv
// collision_life_ctrl
//   Once per video frame, checks the plane sprite against up to N_OBJ obstacle
//   slots. Any overlap costs exactly one life and opens an invulnerability
//   window that lasts a fixed number of evaluated frames. Running out of lives
//   enters a terminal DEAD state that only reset clears.
//
// Ports
//   clk         system clock
//   resetn      asynchronous active-low reset
//   frame_tick  one-cycle pulse per frame; coordinates are stable in that cycle
//   enable      game running; 0 pauses (ticks ignored, state held)
//   plane_y     plane top y
//   obj_valid   per-slot active flag
//   obj_kind    per-slot kind: 0 = ground obstacle, 1 = box
//   obj_x/y/w/h packed per-slot geometry, slot i at [i*COORD_W +: COORD_W]
//   life        remaining lives
//   hit         one-cycle pulse when a life is lost
//   hit_id      lowest slot index involved in the last hit
//   invuln      high while invulnerable
//   game_over   high in DEAD or while resetn is low
module collision_life_ctrl #(
    parameter int COORD_W       = 10,
    parameter int N_OBJ         = 4,
    parameter int PLANE_X       = 100,
    parameter int PLANE_W       = 16,
    parameter int PLANE_H       = 16,
    parameter int LIVES         = 3,
    parameter int LIFE_W        = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int ID_W          = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       frame_tick,
    input  logic                       enable,
    input  logic [COORD_W-1:0]         plane_y,
    input  logic [N_OBJ-1:0]           obj_valid,
    input  logic [N_OBJ-1:0]           obj_kind,
    input  logic [N_OBJ*COORD_W-1:0]   obj_x,
    input  logic [N_OBJ*COORD_W-1:0]   obj_y,
    input  logic [N_OBJ*COORD_W-1:0]   obj_w,
    input  logic [N_OBJ*COORD_W-1:0]   obj_h,
    output logic [LIFE_W-1:0]          life,
    output logic                       hit,
    output logic [ID_W-1:0]            hit_id,
    output logic                       invuln,
    output logic                       game_over
);

    // One extra bit so coordinate sums never wrap.
    localparam int CW1   = COORD_W + 1;
    localparam int CNT_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);

    localparam logic [CW1-1:0]    PX_LO    = CW1'(PLANE_X);
    localparam logic [CW1-1:0]    PX_HI    = CW1'(PLANE_X + PLANE_W);
    localparam logic [CW1-1:0]    PH       = CW1'(PLANE_H);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(INVULN_FRAMES);
    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIVES);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    function automatic logic [CW1-1:0] ext(input logic [COORD_W-1:0] v);
        return {1'b0, v};
    endfunction

    // Ground obstacles extend to the screen bottom, so only their top edge
    // matters vertically; boxes need a full two-sided Y overlap.
    function automatic logic overlap(
        input logic               kind,
        input logic [COORD_W-1:0] ox,
        input logic [COORD_W-1:0] oy,
        input logic [COORD_W-1:0] ow,
        input logic [COORD_W-1:0] oh,
        input logic [COORD_W-1:0] py
    );
        logic x_ov;
        logic y_top;
        logic y_bot;
        x_ov  = (PX_HI >= ext(ox)) && (PX_LO <= ext(ox) + ext(ow));
        y_top = (ext(py) + PH) >= ext(oy);
        y_bot = ext(py) <= (ext(oy) + ext(oh));
        return x_ov && y_top && (kind ? y_bot : 1'b1);
    endfunction

    // Life counter saturates at zero.
    function automatic logic [LIFE_W-1:0] sat_dec(input logic [LIFE_W-1:0] v);
        return (v == '0) ? '0 : v - LIFE_W'(1);
    endfunction

    function automatic logic [ID_W-1:0] lowest_idx(input logic [N_OBJ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    logic [N_OBJ-1:0]  ov_p0;
    logic [N_OBJ-1:0]  ov_p1;
    logic              vld_p1;

    state_t            state_q, state_d;
    logic [LIFE_W-1:0] life_q, life_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   hit_id_q, hit_id_d;
    logic              hit_q, hit_d;
    logic              invuln_q;

    // ---- stage 0: combinational per-slot overlap ----
    always_comb begin
        ov_p0 = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            ov_p0[i] = obj_valid[i] & overlap(obj_kind[i],
                                              obj_x[i*COORD_W +: COORD_W],
                                              obj_y[i*COORD_W +: COORD_W],
                                              obj_w[i*COORD_W +: COORD_W],
                                              obj_h[i*COORD_W +: COORD_W],
                                              plane_y);
        end
    end

    // ---- stage 1: capture overlap vector on enabled frame ticks ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
            ov_p1  <= '0;
        end else begin
            vld_p1 <= frame_tick & enable;
            if (frame_tick & enable) ov_p1 <= ov_p0;
        end
    end

    // ---- stage 2: life / invulnerability FSM ----
    always_comb begin
        state_d  = state_q;
        life_d   = life_q;
        cnt_d    = cnt_q;
        hit_id_d = hit_id_q;
        hit_d    = 1'b0;
        if (vld_p1) begin
            unique case (state_q)
                ST_ALIVE: begin
                    if (|ov_p1) begin
                        life_d   = sat_dec(life_q);
                        hit_d    = 1'b1;
                        hit_id_d = lowest_idx(ov_p1);
                        cnt_d    = CNT_INIT;
                        state_d  = (life_q <= LIFE_W'(1)) ? ST_DEAD : ST_INVULN;
                    end
                end
                ST_INVULN: begin
                    // The frame that finds cnt==0 still ignores collisions,
                    // giving a window of INVULN_FRAMES+1 evaluated frames.
                    if (cnt_q == '0) state_d = ST_ALIVE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_DEAD: begin
                    state_d = ST_DEAD;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_ALIVE;
            life_q   <= LIFE_INIT;
            cnt_q    <= '0;
            hit_id_q <= '0;
            hit_q    <= 1'b0;
            invuln_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            life_q   <= life_d;
            cnt_q    <= cnt_d;
            hit_id_q <= hit_id_d;
            hit_q    <= hit_d;
            invuln_q <= (state_d == ST_INVULN);
        end
    end

    assign life      = life_q;
    assign hit       = hit_q;
    assign hit_id    = hit_id_q;
    assign invuln    = invuln_q;
    // Held high during reset so the game FSM never sees a live game mid-reset.
    assign game_over = ~resetn | (state_q == ST_DEAD);

endmodule

// File: tb/tb_collision_life_ctrl.sv
// Directed testbench for collision_life_ctrl with default parameters.
module tb_collision_life_ctrl;

    localparam int CW = 10;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic            frame_tick;
    logic            enable;
    logic [CW-1:0]   plane_y;
    logic [N-1:0]    obj_valid;
    logic [N-1:0]    obj_kind;
    logic [N*CW-1:0] obj_x, obj_y, obj_w, obj_h;
    logic [2:0]      life;
    logic            hit;
    logic [1:0]      hit_id;
    logic            invuln;
    logic            game_over;

    int n_tests = 0;
    int n_fail  = 0;

    collision_life_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .enable     (enable),
        .plane_y    (plane_y),
        .obj_valid  (obj_valid),
        .obj_kind   (obj_kind),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_w      (obj_w),
        .obj_h      (obj_h),
        .life       (life),
        .hit        (hit),
        .hit_id     (hit_id),
        .invuln     (invuln),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_objs();
        obj_valid = '0;
        obj_kind  = '0;
        obj_x     = '0;
        obj_y     = '0;
        obj_w     = '0;
        obj_h     = '0;
    endtask

    task automatic set_obj(input int s, input logic k, input int x, input int y,
                           input int w, input int h);
        obj_valid[s]        = 1'b1;
        obj_kind[s]         = k;
        obj_x[s*CW +: CW]   = CW'(x);
        obj_y[s*CW +: CW]   = CW'(y);
        obj_w[s*CW +: CW]   = CW'(w);
        obj_h[s*CW +: CW]   = CW'(h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn     = 1'b0;
        frame_tick = 1'b0;
        enable     = 1'b1;
        plane_y    = '0;
        clear_objs();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Tick high across one rising edge; returns on the negedge after the
    // following rising edge, where the stage-2 result is visible.
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn     = 1'b0;
        frame_tick = 1'b0;
        enable     = 1'b1;
        plane_y    = '0;
        clear_objs();
        #2;
        n_tests++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL reset_game_over_low: got %0b want 1", game_over); end
        n_tests++; if (life !== 3'd3) begin n_fail++; $display("FAIL reset_life: got %0d want 3", life); end
        n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b want 0", hit); end
        n_tests++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL reset_invuln: got %0b want 0", invuln); end
        n_tests++; if (hit_id !== 2'd0) begin n_fail++; $display("FAIL reset_hit_id: got %0d want 0", hit_id); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_tests++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over_released: got %0b want 0", game_over); end
        n_tests++; if (life !== 3'd3) begin n_fail++; $display("FAIL reset_life_released: got %0d want 3", life); end
    endtask

    task automatic test_single_hit();
        do_reset();
        set_obj(2, 1'b0, 90, 200, 20, 0);
        plane_y = 10'd190;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL single_hit_early: got %0b want 0", hit); end
        @(negedge clk);
        n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL single_hit_pulse: got %0b want 1", hit); end
        n_tests++; if (hit_id !== 2'd2) begin n_fail++; $display("FAIL single_hit_id: got %0d want 2", hit_id); end
        n_tests++; if (life !== 3'd2) begin n_fail++; $display("FAIL single_hit_life: got %0d want 2", life); end
        n_tests++; if (invuln !== 1'b1) begin n_fail++; $display("FAIL single_hit_invuln: got %0b want 1", invuln); end
        @(negedge clk);
        n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL single_hit_width: got %0b want 0", hit); end
    endtask

    task automatic test_hold_overlap();
        int hits = 0;
        int first = 0;
        int second = 0;
        do_reset();
        set_obj(1, 1'b0, 90, 200, 20, 0);
        plane_y = 10'd190;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (hit === 1'b1) begin
                hits++;
                if (hits == 1) first = k;
                else if (hits == 2) second = k;
            end
        end
        n_tests++; if (hits != 2) begin n_fail++; $display("FAIL hold_hit_count: got %0d want 2", hits); end
        n_tests++; if (first != 1) begin n_fail++; $display("FAIL hold_first_tick: got %0d want 1", first); end
        n_tests++; if (second != 63) begin n_fail++; $display("FAIL hold_second_tick: got %0d want 63", second); end
        n_tests++; if (life !== 3'd1) begin n_fail++; $display("FAIL hold_life: got %0d want 1", life); end
    endtask

    task automatic test_multi_overlap();
        do_reset();
        set_obj(0, 1'b1, 100, 180, 16, 16);
        set_obj(3, 1'b0, 110, 200, 10, 0);
        plane_y = 10'd190;
        tick();
        n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL multi_hit: got %0b want 1", hit); end
        n_tests++; if (hit_id !== 2'd0) begin n_fail++; $display("FAIL multi_hit_id: got %0d want 0", hit_id); end
        n_tests++; if (life !== 3'd2) begin n_fail++; $display("FAIL multi_life: got %0d want 2", life); end
    endtask

    task automatic test_game_over();
        int hits = 0;
        int last = 0;
        do_reset();
        set_obj(0, 1'b0, 90, 200, 20, 0);
        plane_y = 10'd190;
        for (int k = 1; k <= 135; k++) begin
            tick();
            if (hit === 1'b1) begin
                hits++;
                last = k;
            end
        end
        n_tests++; if (hits != 3) begin n_fail++; $display("FAIL gameover_hit_count: got %0d want 3", hits); end
        n_tests++; if (last != 125) begin n_fail++; $display("FAIL gameover_last_hit: got %0d want 125", last); end
        n_tests++; if (life !== 3'd0) begin n_fail++; $display("FAIL gameover_life: got %0d want 0", life); end
        n_tests++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL gameover_flag: got %0b want 1", game_over); end
        n_tests++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL gameover_invuln: got %0b want 0", invuln); end
        // Reset asserted between clock edges must act immediately.
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_tests++; if (life !== 3'd3) begin n_fail++; $display("FAIL async_reset_life: got %0d want 3", life); end
        n_tests++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL async_reset_game_over: got %0b want 1", game_over); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_tests++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL async_reset_release: got %0b want 0", game_over); end
    endtask

    task automatic test_box_edges();
        do_reset();
        set_obj(1, 1'b1, 100, 100, 16, 16);
        plane_y = 10'd84;
        tick();
        n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL box_touch: got %0b want 1", hit); end

        do_reset();
        set_obj(1, 1'b1, 100, 100, 16, 16);
        plane_y = 10'd83;
        tick();
        n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL box_gap: got %0b want 0", hit); end
        n_tests++; if (life !== 3'd3) begin n_fail++; $display("FAIL box_gap_life: got %0d want 3", life); end

        plane_y = 10'd84;
        obj_valid = '0;
        tick();
        n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL invalid_slot: got %0b want 0", hit); end

        obj_valid[1] = 1'b1;
        enable = 1'b0;
        tick();
        n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL paused_hit: got %0b want 0", hit); end
        n_tests++; if (life !== 3'd3) begin n_fail++; $display("FAIL paused_life: got %0d want 3", life); end
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_obj(3, 1'b1, 100, 100, 16, 16);
        obj_valid = '0;
        plane_y = 10'd90;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        obj_valid[3] = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got %0b want 0", hit); end
        @(negedge clk);
        n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %0b want 1", hit); end
        n_tests++; if (hit_id !== 2'd3) begin n_fail++; $display("FAIL b2b_hit_id: got %0d want 3", hit_id); end
        n_tests++; if (life !== 3'd2) begin n_fail++; $display("FAIL b2b_life: got %0d want 2", life); end
        @(negedge clk);
        n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_width: got %0b want 0", hit); end
    endtask

    initial begin
        resetn     = 1'b0;
        frame_tick = 1'b0;
        enable     = 1'b1;
        plane_y    = '0;
        clear_objs();
        test_reset();
        test_single_hit();
        test_hold_overlap();
        test_multi_overlap();
        test_game_over();
        test_box_edges();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_life_ctrl.md
# collision_life_ctrl

Parametrised collision detector and life manager for the plane game. It compares the plane sprite against up to N_OBJ obstacles (mountains, lava blobs, future object types) once per video frame. Each collision event costs exactly one life and is followed by a frame-counted invulnerability window. A sticky game-over flag goes to the top-level game FSM. It sits between the object-position generators and the game-control/HUD logic.

## Interface
Parameters:
- COORD_W, 10, coordinate width in bits
- N_OBJ, 4, number of obstacle slots
- PLANE_X, 100, fixed plane left x coordinate
- PLANE_W, 16, plane width in pixels
- PLANE_H, 16, plane height in pixels
- LIVES, 3, lives at reset
- LIFE_W, 3, width of life counter (must hold LIVES)
- INVULN_FRAMES, 60, frames of invulnerability after a hit
- ID_W, 2, width of hit_id (must be ≥ clog2(N_OBJ), minimum 1)

Ports (reset: resetn, asynchronous, active-low; clock: clk):
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame; coordinates are stable in this cycle
- enable  in  1  game running; 0 = pause (ticks ignored, state held)
- plane_y  in  COORD_W  plane top y
- obj_valid  in  N_OBJ  slot i active
- obj_kind  in  N_OBJ  0 = ground obstacle (extends to screen bottom), 1 = box
- obj_x, obj_y, obj_w, obj_h  in  N_OBJ*COORD_W each  packed per-slot left x, top y, width, height; slot i at bits [i*COORD_W +: COORD_W]
- life  out  LIFE_W  remaining lives
- hit  out  1  one-cycle pulse when a life is lost
- hit_id  out  ID_W  slot that caused the last hit
- invuln  out  1  high while invulnerable
- game_over  out  1  high when lives are exhausted, or while resetn is low

## Operation
Overlap test for slot i is combinational. All sums are computed in COORD_W+1 bits, so they never wrap.
- X overlap: PLANE_X+PLANE_W ≥ ox and PLANE_X ≤ ox+ow.
- Box (kind=1) also needs Y overlap: plane_y+PLANE_H ≥ oy and plane_y ≤ oy+oh.
- Ground (kind=0) needs only plane_y+PLANE_H ≥ oy.
- Final result: ov[i] = obj_valid[i] & overlap.

Stage 1: on a clk edge with frame_tick & enable, register ov into ov_q and set eval_q=1. Otherwise eval_q=0.

Stage 2 FSM, acting only on edges where eval_q=1:
- ALIVE:
  - If |ov_q: life ← life−1, hit ← 1, hit_id ← lowest set index of ov_q, cnt ← INVULN_FRAMES.
  - Next state is DEAD if the old life was 1, otherwise INVULN.
  - If ov_q is all zero: no action.
- INVULN:
  - Collisions are ignored.
  - If cnt==0 go to ALIVE, otherwise cnt ← cnt−1.
- DEAD: terminal until reset. Ticks are ignored and life stays 0.

Other rules:
- Several objects overlapping in the same frame cost one life only.
- life never underflows.
- hit is a registered pulse, high for exactly one cycle. It is 0 on every other cycle.
- invuln = (state==INVULN), registered.
- game_over = ~resetn | (state==DEAD). This is the only output with a combinational path.
- enable=0 blocks stage 1. A pending eval_q still completes. cnt does not advance while paused.

## Timing
- Reset values: life=LIVES, hit=0, hit_id=0, invuln=0, game_over=1 while resetn low and 0 after release, state ALIVE, cnt=0, ov_q=0, eval_q=0.
- Latency: frame_tick sampled at edge E. At edge E+1, life, hit, hit_id, invuln and the DEAD state all update. game_over rises after E+1.
- Back-to-back frame_tick on consecutive cycles is legal. Each tick is processed in order with a throughput of one per cycle.
- The invulnerability window lasts INVULN_FRAMES+1 evaluated frames, including the frame that leaves INVULN. The first tick that can cost another life comes after that.
- resetn asserted mid-window or in DEAD returns all state to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset with defaults → life=3, game_over=1 during reset and 0 after, hit=0, invuln=0.
- Slot 2 ground obstacle at oy=200, plane_y=190, one tick → exactly one hit pulse 2 edges after the tick, hit_id=2, life=2, invuln=1.
- Plane held in overlap for 80 ticks with INVULN_FRAMES=60 → exactly two hits: at tick 1 and at tick 63.
- Slots 0 and 3 overlap in the same tick → one life lost, hit_id=0.
- Three separated collisions → life=0, game_over=1. A further overlap causes no hit and life stays 0. Pulsing resetn restores life=3.
- Box at ox=100, oy=100, ow=oh=16 with plane_y=84 (edge touch) → hit. With plane_y=83 → no hit. obj_valid=0 → no hit. enable=0 with overlap → no hit and life unchanged.
